// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit,
// round-robin pick, registered broadcast to RS/LSQ/regfile.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*LABEL_W-1:0] src_label,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic                       err_zero_label
);

  localparam int PW = $clog2(NUM_SRC);
  localparam logic [PW:0] N = (PW+1)'(NUM_SRC);

  logic [NUM_SRC-1:0] held_q, held_d;
  logic [NUM_SRC-1:0] grant, take, lbl_nz;
  logic [LABEL_W-1:0] hlabel_q [NUM_SRC];
  logic [DATA_W-1:0]  hdata_q  [NUM_SRC];
  logic [PW-1:0]      rr_q, rr_d, gidx;
  logic [PW:0]        idx;
  logic               gnt_any, zero_hit;

  logic               bcen_q;
  logic [LABEL_W-1:0] bclabel_q;
  logic [DATA_W-1:0]  bcdata_q;
  logic               err_q;

  // Scan upward from rr_q; index wraps at NUM_SRC, not a power of two.
  always_comb begin
    grant   = '0;
    gidx    = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int o = 0; o < NUM_SRC; o++) begin
      idx = {1'b0, rr_q} + (PW+1)'(o);
      if (idx >= N) idx = idx - N;
      if (!gnt_any && held_q[idx[PW-1:0]]) begin
        gnt_any                = 1'b1;
        grant[idx[PW-1:0]]     = 1'b1;
        gidx                   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      if (gidx == PW'(NUM_SRC-1)) rr_d = '0;
      else                        rr_d = gidx + PW'(1);
    end
  end

  always_comb begin
    lbl_nz = '0;
    for (int i = 0; i < NUM_SRC; i++)
      lbl_nz[i] = |src_label[i*LABEL_W +: LABEL_W];
  end

  assign src_ready = ~held_q | grant;
  assign take      = src_valid & src_ready & lbl_nz;
  assign zero_hit  = |(src_valid & src_ready & ~lbl_nz);
  assign held_d    = (held_q & ~grant) | take;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      held_q    <= '0;
      rr_q      <= '0;
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hlabel_q[i] <= '0;
        hdata_q[i]  <= '0;
      end
    end else begin
      held_q <= held_d;
      rr_q   <= rr_d;
      bcen_q <= gnt_any;
      if (gnt_any) begin
        bclabel_q <= hlabel_q[gidx];
        bcdata_q  <= hdata_q[gidx];
      end
      if (zero_hit) err_q <= 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (take[i]) begin
          hlabel_q[i] <= src_label[i*LABEL_W +: LABEL_W];
          hdata_q[i]  <= src_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign BCEN           = bcen_q;
  assign BClabel        = bclabel_q;
  assign BCdata         = bcdata_q;
  assign err_zero_label = err_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo core. It collects completed results (label + data) from the functional units (ALU, MUL, DIV, load/store queue) into one holding slot per unit. It picks one held result per cycle, round-robin, and drives the registered broadcast `BCEN`/`BClabel`/`BCdata` consumed by every reservation station, the load/store queue and the register file.

## Interface
Parameters:
- `NUM_SRC`, 4, number of result producers; legal 2..8. Index 0 = ALU, 1 = MUL, 2 = DIV, 3 = load/store.
- `DATA_W`, 32, result data width.
- `LABEL_W`, 4, reservation-station tag width; tag 0 means "no producer" and is never broadcast.

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on the rising edge.
- `nRST`  input  1  asynchronous, active-high reset (port name kept for codebase consistency; asserting it high resets immediately).
- `src_valid`  input  NUM_SRC  bit i: unit i presents a result this cycle.
- `src_label`  input  NUM_SRC*LABEL_W  tag of unit i in slice [i*LABEL_W +: LABEL_W].
- `src_data`  input  NUM_SRC*DATA_W  result of unit i in slice [i*DATA_W +: DATA_W].
- `src_ready`  output  NUM_SRC  bit i: slot i accepts this cycle. Combinational.
- `BCEN`  output  1  broadcast valid. Registered.
- `BClabel`  output  LABEL_W  broadcast tag. Registered.
- `BCdata`  output  DATA_W  broadcast data. Registered.
- `err_zero_label`  output  1  sticky flag, set when a tag-0 result is accepted.

## Operation
- Per-source slot: `held[i]`, `hlabel[i]`, `hdata[i]`.
- `src_ready[i] = !held[i] || grant[i]`, so a slot can be drained and refilled in the same cycle.
- Handshake: a transfer occurs when `src_valid[i] && src_ready[i]`.
  - On transfer with nonzero label, the slot loads the label and data and sets `held[i]`.
  - On transfer with label 0, the result is discarded, `held[i]` is unchanged (or cleared if it was granted), and `err_zero_label` is set.
  - `src_valid` while not ready: the source must hold its label and data stable. The arbiter takes no other action.
- Arbitration:
  - Combinational one-hot `grant` over the `held` vector.
  - Search starts at index `rr_ptr` and goes upward, wrapping modulo NUM_SRC.
  - At most one grant per cycle.
- On a grant to k:
  - `BCEN`<=1, `BClabel`<=`hlabel[k]`, `BCdata`<=`hdata[k]`.
  - `held[k]` clears unless refilled in the same cycle.
  - `rr_ptr` <= (k+1) mod NUM_SRC.
- No grant: `BCEN`<=0. `BClabel`/`BCdata` keep their previous values. `rr_ptr` is unchanged.
- `rr_ptr` is $clog2(NUM_SRC) bits wide. The increment wraps explicitly at NUM_SRC, which is not necessarily a power of two.
- `err_zero_label` clears only on reset.

## Timing
- Reset (async, while `nRST`=1):
  - `held`=0, so `src_ready` is all ones.
  - `rr_ptr`=0.
  - `BCEN`=0, `BClabel`=0, `BCdata`=0.
  - `err_zero_label`=0.
  - Hold registers are cleared to 0.
- Reset mid-operation: held results are lost and no broadcast issues. Producers re-present them after reset.
- Latency:
  - Result accepted at edge E.
  - Earliest grant is in the cycle after E.
  - `BCEN`=1 is visible for exactly one cycle after the edge E+1.
  - Minimum latency is 2 cycles, valid-in to broadcast.
- Throughput: one broadcast per cycle. Any single source can sustain one result per cycle through its slot.
- Fairness: with all slots continuously full, each source is granted once every NUM_SRC cycles.
- Simultaneous events:
  - Grant and refill of the same slot in one cycle is legal. The new entry is eligible the next cycle, and `rr_ptr` has already moved past it.
- Full: all slots held and no refill. `src_ready` is low only for the ungranted held slots.
- Empty: no grant; `BCEN`=0 the next cycle.

## Test plan
1. Single result: after reset, drive src 0 valid with label 3 and data 0x0000_00AA for one cycle. Required: `src_ready[0]`=1; `BCEN`=1, `BClabel`=3, `BCdata`=0xAA two cycles later for exactly one cycle; then `BCEN`=0.
2. Contention: all 4 sources valid in the same cycle with labels 1,2,3,4 and data 0x10..0x13, `rr_ptr`=0. Required: broadcasts on 4 consecutive cycles in order label 1,2,3,4; `rr_ptr` returns to 0.
3. Backpressure: src 2 presents label 5, then holds valid with label 6 while its slot is full and src 1 wins. Required: `src_ready[2]`=0 until slot 2 is granted; label 6 is accepted that cycle and broadcast later; no label is lost or duplicated.
4. Streaming: src 1 valid every cycle with labels 1..8 and no other traffic. Required: 8 consecutive `BCEN` cycles with labels 1..8 in order, and `src_ready[1]` always 1.
5. Zero tag: src 3 presents label 0 with data 0xDEAD. Required: it is accepted, no broadcast occurs, `err_zero_label`=1 and stays 1 until reset.
6. Reset mid-operation: 3 slots held, assert `nRST` asynchronously between edges. Required: `BCEN`, `BClabel`, `BCdata` go to 0 immediately; no broadcast after release; `src_ready` is all ones.
